// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with trap entry/return, mcycle and optional minstret counters.
// Build option: define CSR_FILE_MINSTRET_EN to implement minstret/instret (and high halves).
module csr_file #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter int              CNT_W     = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_epc_i,
    input  logic            mret_i,
    input  logic            retire_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            irq_en_o,
    output logic [XLEN-1:0] mie_o
);
    localparam int              CW2        = 2 * XLEN;
    localparam logic [1:0]      OP_NONE    = 2'b00;
    localparam logic [1:0]      OP_RW      = 2'b01;
    localparam logic [1:0]      OP_RS      = 2'b10;
    localparam logic [1:0]      OP_RC      = 2'b11;
    localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);
    localparam logic [XLEN-1:0] MEPC_MASK  = ~XLEN'(3);
`ifdef CSR_FILE_MINSTRET_EN
    localparam bit IR_EN = 1'b1;
`else
    localparam bit IR_EN = 1'b0;
`endif

    logic             mstatus_mie, mstatus_mpie;
    logic [XLEN-1:0]  mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic             inhibit_cy, inhibit_ir;
    logic [CNT_W-1:0] mcycle_q;
    logic [CW2-1:0]   mcycle_ext, minstret_ext;
    logic [CNT_W-1:0] cy_wr;

    logic [XLEN-1:0]  mstatus_rd, mcountinhibit_rd, wval;
    logic             hit, ro, wr_op, do_write, we;
    logic             sel_mstatus, sel_mie, sel_mtvec, sel_minh, sel_mscratch;
    logic             sel_mepc, sel_mcause, sel_cy_lo, sel_cy_hi, sel_ir_lo, sel_ir_hi;

    assign mcycle_ext = CW2'(mcycle_q);

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mstatus_mpie;
        mstatus_rd[3]     = mstatus_mie;
        mcountinhibit_rd    = '0;
        mcountinhibit_rd[0] = inhibit_cy;
        mcountinhibit_rd[2] = inhibit_ir;
    end

    // Address decode: read mux, write selects and legality.
    always_comb begin
        csr_rdata_o  = '0;
        hit          = 1'b1;
        ro           = 1'b0;
        sel_mstatus  = 1'b0;
        sel_mie      = 1'b0;
        sel_mtvec    = 1'b0;
        sel_minh     = 1'b0;
        sel_mscratch = 1'b0;
        sel_mepc     = 1'b0;
        sel_mcause   = 1'b0;
        sel_cy_lo    = 1'b0;
        sel_cy_hi    = 1'b0;
        sel_ir_lo    = 1'b0;
        sel_ir_hi    = 1'b0;
        case (csr_addr_i)
            12'h300: begin csr_rdata_o = mstatus_rd;       sel_mstatus  = 1'b1; end
            12'h304: begin csr_rdata_o = mie_q;            sel_mie      = 1'b1; end
            12'h305: begin csr_rdata_o = mtvec_q;          sel_mtvec    = 1'b1; end
            12'h320: begin csr_rdata_o = mcountinhibit_rd; sel_minh     = 1'b1; end
            12'h340: begin csr_rdata_o = mscratch_q;       sel_mscratch = 1'b1; end
            12'h341: begin csr_rdata_o = mepc_q;           sel_mepc     = 1'b1; end
            12'h342: begin csr_rdata_o = mcause_q;         sel_mcause   = 1'b1; end
            12'hB00: begin csr_rdata_o = mcycle_ext[XLEN-1:0];   sel_cy_lo = 1'b1; end
            12'hB02: begin csr_rdata_o = minstret_ext[XLEN-1:0]; sel_ir_lo = 1'b1; end
            12'hC00: begin csr_rdata_o = mcycle_ext[XLEN-1:0];   ro = 1'b1; end
            // With minstret compiled out its addresses read 0 and silently drop writes.
            12'hC02: begin csr_rdata_o = minstret_ext[XLEN-1:0]; ro = IR_EN; end
            12'hB80: if (XLEN == 32) begin csr_rdata_o = mcycle_ext[CW2-1:XLEN]; sel_cy_hi = 1'b1; end
                     else hit = 1'b0;
            12'hB82: if (XLEN == 32) begin csr_rdata_o = minstret_ext[CW2-1:XLEN]; sel_ir_hi = 1'b1; end
                     else hit = 1'b0;
            12'hC80: if (XLEN == 32) begin csr_rdata_o = mcycle_ext[CW2-1:XLEN]; ro = 1'b1; end
                     else hit = 1'b0;
            12'hC82: if (XLEN == 32) begin csr_rdata_o = minstret_ext[CW2-1:XLEN]; ro = IR_EN; end
                     else hit = 1'b0;
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op_i)
            OP_RS:   wval = csr_rdata_o | csr_wdata_i;
            OP_RC:   wval = csr_rdata_o & ~csr_wdata_i;
            default: wval = csr_wdata_i;
        endcase
    end

    assign wr_op         = (csr_op_i != OP_NONE);
    assign csr_illegal_o = !hit || (ro && wr_op);
    assign do_write      = (csr_op_i == OP_RW) || (wr_op && (csr_wdata_i != '0));
    // Trap and mret both pre-empt the EX write in the same cycle.
    assign we            = do_write && !csr_illegal_o && !trap_i && !mret_i;
    assign cy_wr = CNT_W'(sel_cy_hi ? {wval, mcycle_ext[XLEN-1:0]} : {mcycle_ext[CW2-1:XLEN], wval});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mtvec_q      <= MTVEC_RST & MTVEC_MASK;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            inhibit_cy   <= 1'b0;
            inhibit_ir   <= 1'b0;
        end else if (trap_i) begin
            mepc_q       <= trap_epc_i & MEPC_MASK;
            mcause_q     <= trap_cause_i;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_i) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (we) begin
            if (sel_mstatus) begin
                mstatus_mie  <= wval[3];
                mstatus_mpie <= wval[7];
            end
            if (sel_mie)      mie_q      <= wval;
            if (sel_mtvec)    mtvec_q    <= wval & MTVEC_MASK;
            if (sel_mscratch) mscratch_q <= wval;
            if (sel_mepc)     mepc_q     <= wval & MEPC_MASK;
            if (sel_mcause)   mcause_q   <= wval;
            if (sel_minh) begin
                inhibit_cy <= wval[0];
                inhibit_ir <= wval[2];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                           mcycle_q <= '0;
        else if (we && (sel_cy_lo || sel_cy_hi)) mcycle_q <= cy_wr;
        else if (!inhibit_cy)                mcycle_q <= mcycle_q + CNT_W'(1);
    end

`ifdef CSR_FILE_MINSTRET_EN
    logic [CNT_W-1:0] minstret_q;
    logic [CNT_W-1:0] ir_wr;

    assign minstret_ext = CW2'(minstret_q);
    assign ir_wr = CNT_W'(sel_ir_hi ? {wval, minstret_ext[XLEN-1:0]} : {minstret_ext[CW2-1:XLEN], wval});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                minstret_q <= '0;
        else if (we && (sel_ir_lo || sel_ir_hi))  minstret_q <= ir_wr;
        else if (retire_i && !inhibit_ir)         minstret_q <= minstret_q + CNT_W'(1);
    end
`else
    logic unused_ir;
    assign minstret_ext = '0;
    assign unused_ir    = ^{retire_i, sel_ir_lo, sel_ir_hi, inhibit_ir};
`endif

    assign mtvec_o  = mtvec_q;
    assign mepc_o   = mepc_q;
    assign irq_en_o = mstatus_mie;
    assign mie_o    = mie_q;
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: table-driven CSR access vectors plus hand sequences for traps, counters and reset.
`timescale 1ns/1ps
module tb_csr_file;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
`ifdef CSR_FILE_MINSTRET_EN
    localparam bit IR_ON = 1'b1;
`else
    localparam bit IR_ON = 1'b0;
`endif

    logic        clk, rst_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i, csr_rdata_o;
    logic        csr_illegal_o;
    logic        trap_i, mret_i, retire_i;
    logic [31:0] trap_cause_i, trap_epc_i;
    logic [31:0] mtvec_o, mepc_o, mie_o;
    logic        irq_en_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        chk_rdata;
        logic        exp_ill;
    } vec_t;
    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    csr_file #(.XLEN(32), .MTVEC_RST(MTVEC_RST), .CNT_W(64)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
        .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_epc_i(trap_epc_i),
        .mret_i(mret_i), .retire_i(retire_i),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_en_o(irq_en_o), .mie_o(mie_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_op_i    = op;
        csr_addr_i  = addr;
        csr_wdata_i = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        csr_op_i = 2'b00;
        trap_i   = 1'b0;
        mret_i   = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
        drive(2'b00, addr, 32'h0);
        #1;
        check(name, csr_rdata_o, exp);
    endtask

    task automatic add_vec(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp, input logic chk, input logic ill);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wd;
        v.exp_rdata = exp; v.chk_rdata = chk; v.exp_ill = ill;
        vecs.push_back(v);
    endtask

    initial begin
        rst_i = 1'b1; trap_i = 1'b0; mret_i = 1'b0; retire_i = 1'b0;
        trap_cause_i = '0; trap_epc_i = '0;
        drive(2'b00, 12'h000, 32'h0);

        add_vec(2'b00, 12'h300, 32'h0,          32'h0000_1800, 1, 0);
        add_vec(2'b00, 12'h305, 32'h0,          32'h0000_0100, 1, 0);
        add_vec(2'b01, 12'h305, 32'h8000_0003,  32'h0000_0100, 1, 0);
        add_vec(2'b00, 12'h305, 32'h0,          32'h8000_0001, 1, 0);
        add_vec(2'b01, 12'h340, 32'hDEAD_BEEF,  32'h0,         1, 0);
        add_vec(2'b10, 12'h340, 32'h0000_0010,  32'hDEAD_BEEF, 1, 0);
        add_vec(2'b11, 12'h340, 32'hFF00_0000,  32'hDEAD_BEFF, 1, 0);
        add_vec(2'b00, 12'h340, 32'h0,          32'h00AD_BEFF, 1, 0);
        add_vec(2'b01, 12'h300, 32'hFFFF_FFFF,  32'h0000_1800, 1, 0);
        add_vec(2'b00, 12'h300, 32'h0,          32'h0000_1888, 1, 0);
        add_vec(2'b10, 12'h300, 32'h0,          32'h0000_1888, 1, 0);
        add_vec(2'b11, 12'h300, 32'h0000_0008,  32'h0000_1888, 1, 0);
        add_vec(2'b00, 12'h300, 32'h0,          32'h0000_1880, 1, 0);
        add_vec(2'b01, 12'h341, 32'h0000_0207,  32'h0,         1, 0);
        add_vec(2'b00, 12'h341, 32'h0,          32'h0000_0204, 1, 0);
        add_vec(2'b01, 12'h304, 32'h0000_0888,  32'h0,         1, 0);
        add_vec(2'b00, 12'h304, 32'h0,          32'h0000_0888, 1, 0);
        add_vec(2'b01, 12'h342, 32'h8000_0007,  32'h0,         1, 0);
        add_vec(2'b00, 12'h342, 32'h0,          32'h8000_0007, 1, 0);
        add_vec(2'b00, 12'h123, 32'h0,          32'h0,         1, 1);
        add_vec(2'b01, 12'h123, 32'h5,          32'h0,         1, 1);
        add_vec(2'b01, 12'h320, 32'hFFFF_FFFF,  32'h0,         1, 0);
        add_vec(2'b00, 12'h320, 32'h0,          32'h0000_0005, 1, 0);
        add_vec(2'b01, 12'hB00, 32'h1234_5678,  32'h0,         0, 0);
        add_vec(2'b00, 12'hB00, 32'h0,          32'h1234_5678, 1, 0);
        add_vec(2'b00, 12'hB00, 32'h0,          32'h1234_5678, 1, 0);
        add_vec(2'b01, 12'hB80, 32'h0000_000A,  32'h0,         1, 0);
        add_vec(2'b00, 12'hB80, 32'h0,          32'h0000_000A, 1, 0);
        add_vec(2'b00, 12'hC80, 32'h0,          32'h0000_000A, 1, 0);
        add_vec(2'b01, 12'hC00, 32'h0,          32'h1234_5678, 1, 1);
        add_vec(2'b00, 12'hB00, 32'h0,          32'h1234_5678, 1, 0);
        add_vec(2'b01, 12'hB02, 32'h0000_0055,  32'h0,         0, 0);
        add_vec(2'b00, 12'hB02, 32'h0,          IR_ON ? 32'h55 : 32'h0, 1, 0);
        add_vec(2'b01, 12'hC02, 32'h1,          IR_ON ? 32'h55 : 32'h0, 1, IR_ON);
        add_vec(2'b01, 12'hB82, 32'h7,          32'h0,         1, 0);
        add_vec(2'b00, 12'hC82, 32'h0,          IR_ON ? 32'h7 : 32'h0, 1, 0);
        foreach (vecs[i]) exp_q.push_back(vecs[i].exp_rdata);

        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;

        // Table-driven single-cycle accesses
        foreach (vecs[i]) begin
            logic [31:0] exp;
            drive(vecs[i].op, vecs[i].addr, vecs[i].wdata);
            #3;
            exp = exp_q.pop_front();
            if (vecs[i].chk_rdata) check($sformatf("vec%0d rdata", i), csr_rdata_o, exp);
            check($sformatf("vec%0d illegal", i), {31'b0, csr_illegal_o}, {31'b0, vecs[i].exp_ill});
            tick();
        end
        check("mtvec_o", mtvec_o, 32'h8000_0001);
        check("mepc_o", mepc_o, 32'h0000_0204);
        check("mie_o", mie_o, 32'h0000_0888);
        check("irq_en_o", {31'b0, irq_en_o}, 32'h0);

        // Counters: release inhibit, minstret write vs retire, mcycle carry into high half
        drive(2'b01, 12'h320, 32'h0); #3; check("minh old", csr_rdata_o, 32'h5); tick();
        drive(2'b01, 12'hB02, 32'h0); retire_i = 1'b1; #3;
        check("minstret old", csr_rdata_o, IR_ON ? 32'h55 : 32'h0);
        tick();
        repeat (3) tick();
        retire_i = 1'b0;
        read_chk("minstret count", 12'hB02, IR_ON ? 32'h3 : 32'h0);
        read_chk("minstreth kept", 12'hB82, IR_ON ? 32'h7 : 32'h0);
        tick();
        drive(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
        read_chk("mcycle written", 12'hB00, 32'hFFFF_FFFF); tick();
        read_chk("mcycle wrapped", 12'hB00, 32'h0); tick();
        read_chk("mcycleh carry", 12'hB80, 32'h0000_000B); tick();

        // Trap entry and return
        drive(2'b01, 12'h300, 32'h8); #3; check("mstatus before trap", csr_rdata_o, 32'h1880); tick();
        trap_i = 1'b1; trap_cause_i = 32'h8000_000B; trap_epc_i = 32'h0000_0102; tick();
        check("trap mepc_o", mepc_o, 32'h0000_0100);
        check("trap irq_en_o", {31'b0, irq_en_o}, 32'h0);
        read_chk("trap mcause", 12'h342, 32'h8000_000B);
        read_chk("trap mstatus", 12'h300, 32'h0000_1880);
        tick();
        mret_i = 1'b1; tick();
        check("mret irq_en_o", {31'b0, irq_en_o}, 32'h1);
        read_chk("mret mstatus", 12'h300, 32'h0000_1888);
        tick();

        // Trap/mret pre-empt a same-cycle EX write
        drive(2'b01, 12'h340, 32'h0); tick();
        drive(2'b01, 12'h340, 32'h1234); trap_i = 1'b1; trap_epc_i = 32'h0000_0200; tick();
        read_chk("trap drops write", 12'h340, 32'h0);
        check("trap2 mepc_o", mepc_o, 32'h0000_0200);
        tick();
        drive(2'b01, 12'h340, 32'h77); mret_i = 1'b1; tick();
        read_chk("mret drops write", 12'h340, 32'h0);
        check("mret2 irq_en_o", {31'b0, irq_en_o}, 32'h1);
        tick();

        // trap_i wins over mret_i
        drive(2'b01, 12'h300, 32'h80); tick();
        trap_i = 1'b1; mret_i = 1'b1; trap_epc_i = 32'h0000_0300; tick();
        read_chk("trap beats mret", 12'h300, 32'h0000_1800);
        check("trap beats mret mepc", mepc_o, 32'h0000_0300);
        tick();

        // Asynchronous reset between edges, then inputs ignored while held
        drive(2'b01, 12'h340, 32'h99); tick();
        #2 rst_i = 1'b1;
        #1;
        check("rst mtvec_o", mtvec_o, MTVEC_RST);
        check("rst mepc_o", mepc_o, 32'h0);
        check("rst mie_o", mie_o, 32'h0);
        read_chk("rst mstatus", 12'h300, 32'h0000_1800);
        read_chk("rst mscratch", 12'h340, 32'h0);
        read_chk("rst mcycle", 12'hB00, 32'h0);
        read_chk("rst mcycleh", 12'hB80, 32'h0);
        drive(2'b01, 12'h340, 32'h5); trap_i = 1'b1; retire_i = 1'b1; trap_epc_i = 32'h44;
        @(posedge clk);
        #1;
        rst_i = 1'b0; trap_i = 1'b0; retire_i = 1'b0;
        drive(2'b00, 12'h000, 32'h0);
        check("rst held mepc_o", mepc_o, 32'h0);
        read_chk("rst held mscratch", 12'h340, 32'h0);
        read_chk("rst held mcycle", 12'hB00, 32'h0);
        read_chk("rst held minstret", 12'hB02, 32'h0);
        tick();
        read_chk("first increment", 12'hB00, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
